// File: rtl/tff_count_sequencer.sv
// Sequences a bank of WIDTH T flip-flops as a programmable up/down counter
// with a start/pause/done FSM; optional auto-reload via TFF_SEQ_AUTORELOAD_EN.
module tff_count_sequencer #(
   parameter int WIDTH = 4
) (
   input  logic             clkin,
   input  logic             rstnin,
   input  logic             startin,
   input  logic             stopin,
   input  logic             loadin,
   input  logic             dirin,
   input  logic [WIDTH-1:0] loadvalin,
   input  logic [WIDTH-1:0] limitin,
   output logic [WIDTH-1:0] countout,
   output logic [WIDTH-1:0] tout,
   output logic [1:0]       stateout,
   output logic             busyout,
   output logic             doneout
);

   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_RUN   = 2'b01;
   localparam logic [1:0] ST_PAUSE = 2'b10;
   localparam logic [1:0] ST_DONE  = 2'b11;

   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic [WIDTH-1:0] count_d;
   logic [WIDTH-1:0] step_t;
   logic             chain;
   logic             at_limit;
   logic             stepping;

   assign at_limit = (countout == limitin);

   // Bit i toggles when every lower bit is 1 (up) or 0 (down): a ripple AND chain.
   always_comb begin
      step_t = '0;
      chain  = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         step_t[i] = chain;
         chain     = chain & (dirin ? countout[i] : ~countout[i]);
      end
   end

   // A pause request or terminal count in RUN must hold the bank, so no toggles then.
   assign stepping = rstnin && (state_q == ST_RUN) && !stopin && !at_limit;
   assign tout     = stepping ? step_t : '0;

   always_comb begin
      state_d = state_q;
      count_d = countout ^ tout;
      case (state_q)
         ST_IDLE: begin
            if (loadin) count_d = loadvalin;
            if (startin && !stopin) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (stopin)        state_d = ST_PAUSE;
            else if (at_limit) state_d = ST_DONE;
         end
         ST_PAUSE: begin
            if (stopin)       state_d = ST_IDLE;
            else if (loadin)  count_d = loadvalin;
            else if (startin) state_d = ST_RUN;
         end
         default: begin
`ifdef TFF_SEQ_AUTORELOAD_EN
            count_d = loadvalin;
            state_d = stopin ? ST_PAUSE : ST_RUN;
`else
            state_d = ST_IDLE;
`endif
         end
      endcase
   end

   always_ff @(posedge clkin) begin
      if (!rstnin) begin
         state_q  <= ST_IDLE;
         countout <= '0;
      end else begin
         state_q  <= state_d;
         countout <= count_d;
      end
   end

   assign stateout = state_q;
   assign busyout  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
   assign doneout  = (state_q == ST_DONE);

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Directed-vector bench for tff_count_sequencer (WIDTH=4); the auto-reload
// scenario is selected by TFF_SEQ_AUTORELOAD_EN, matching the RTL build.
module tb_tff_count_sequencer;

   localparam int W = 4;

   logic         clkin;
   logic         rstnin;
   logic         startin;
   logic         stopin;
   logic         loadin;
   logic         dirin;
   logic [W-1:0] loadvalin;
   logic [W-1:0] limitin;
   logic [W-1:0] countout;
   logic [W-1:0] tout;
   logic [1:0]   stateout;
   logic         busyout;
   logic         doneout;

   int n_vec;
   int n_err;
   logic [W-1:0] exp_q[$];

   tff_count_sequencer #(.WIDTH(W)) dut (
      .clkin     (clkin),
      .rstnin    (rstnin),
      .startin   (startin),
      .stopin    (stopin),
      .loadin    (loadin),
      .dirin     (dirin),
      .loadvalin (loadvalin),
      .limitin   (limitin),
      .countout  (countout),
      .tout      (tout),
      .stateout  (stateout),
      .busyout   (busyout),
      .doneout   (doneout)
   );

   // clock / reset
   initial clkin = 1'b0;
   always #5 clkin = ~clkin;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // driver tasks
   task automatic tick();
      @(posedge clkin);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic load_start(input logic [W-1:0] val, input logic [W-1:0] lim, input logic dir);
      loadvalin = val;
      limitin   = lim;
      dirin     = dir;
      loadin    = 1'b1;
      startin   = 1'b1;
      tick();
      loadin    = 1'b0;
      startin   = 1'b0;
   endtask

   task automatic drain_count(input string tag);
      while (exp_q.size() > 0) begin
         tick();
         check_eq(tag, 32'(countout), 32'(exp_q.pop_front()));
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rstnin = 1'b0; startin = 1'b0; stopin = 1'b0; loadin = 1'b0;
      dirin = 1'b1; loadvalin = '0; limitin = '0;
      tick();
      tick();
      check_eq("rst_count", 32'(countout), 32'd0);
      check_eq("rst_state", 32'(stateout), 32'd0);
      check_eq("rst_busy",  32'(busyout),  32'd0);
      check_eq("rst_done",  32'(doneout),  32'd0);
      check_eq("rst_tout",  32'(tout),     32'd0);
      rstnin = 1'b1;
      tick();

`ifdef TFF_SEQ_AUTORELOAD_EN
      // load 2, limit 4, up: 2,3,4,DONE(reload) 2,3,4,DONE then stop -> PAUSE at 2
      load_start(4'd2, 4'd4, 1'b1);
      check_eq("ar_c2", 32'(countout), 32'd2);
      exp_q = {4'd3, 4'd4};
      drain_count("ar_seq1");
      tick();
      check_eq("ar_done1",  32'(doneout),  32'd1);
      check_eq("ar_dcnt1",  32'(countout), 32'd4);
      tick();
      check_eq("ar_reload", 32'(countout), 32'd2);
      check_eq("ar_run",    32'(stateout), 32'd1);
      check_eq("ar_ndone",  32'(doneout),  32'd0);
      exp_q = {4'd3, 4'd4};
      drain_count("ar_seq2");
      tick();
      check_eq("ar_done2",  32'(doneout),  32'd1);
      stopin = 1'b1;
      tick();
      stopin = 1'b0;
      check_eq("ar_pause",  32'(stateout), 32'd2);
      check_eq("ar_pcnt",   32'(countout), 32'd2);
      check_eq("ar_pdone",  32'(doneout),  32'd0);
`else
      // up count: load 3, limit 7
      load_start(4'd3, 4'd7, 1'b1);
      check_eq("up_load",  32'(countout), 32'd3);
      check_eq("up_run",   32'(stateout), 32'd1);
      check_eq("up_busy",  32'(busyout),  32'd1);
      check_eq("up_tout3", 32'(tout),     32'h7);
      exp_q = {4'd4, 4'd5, 4'd6, 4'd7};
      drain_count("up_seq");
      check_eq("up_ndone", 32'(doneout),  32'd0);
      check_eq("up_tlim",  32'(tout),     32'd0);
      tick();
      check_eq("up_done",  32'(doneout),  32'd1);
      check_eq("up_dst",   32'(stateout), 32'd3);
      check_eq("up_dcnt",  32'(countout), 32'd7);
      tick();
      check_eq("up_idle",  32'(stateout), 32'd0);
      check_eq("up_idone", 32'(doneout),  32'd0);
      check_eq("up_ibusy", 32'(busyout),  32'd0);
      check_eq("up_icnt",  32'(countout), 32'd7);

      // down wrap: load 1, limit 14
      load_start(4'd1, 4'd14, 1'b0);
      check_eq("dn_load",  32'(countout), 32'd1);
      tick();
      check_eq("dn_c0",    32'(countout), 32'd0);
      check_eq("dn_tout0", 32'(tout),     32'hf);
      exp_q = {4'd15, 4'd14};
      drain_count("dn_seq");
      tick();
      check_eq("dn_done",  32'(stateout), 32'd3);
      check_eq("dn_dcnt",  32'(countout), 32'd14);
      tick();
      check_eq("dn_idle",  32'(stateout), 32'd0);

      // pause/resume and stop-over-start priority
      load_start(4'd2, 4'd15, 1'b1);
      exp_q = {4'd3, 4'd4, 4'd5};
      drain_count("pr_seq");
      stopin = 1'b1; startin = 1'b1;
      tick();
      stopin = 1'b0; startin = 1'b0;
      check_eq("pr_pause", 32'(stateout), 32'd2);
      check_eq("pr_pcnt",  32'(countout), 32'd5);
      check_eq("pr_ptout", 32'(tout),     32'd0);
      check_eq("pr_pbusy", 32'(busyout),  32'd1);
      loadin = 1'b1; loadvalin = 4'd9;
      tick();
      loadin = 1'b0;
      check_eq("pr_load",  32'(countout), 32'd9);
      check_eq("pr_lst",   32'(stateout), 32'd2);
      startin = 1'b1;
      tick();
      startin = 1'b0;
      check_eq("pr_resume", 32'(stateout), 32'd1);
      exp_q = {4'd10, 4'd11};
      drain_count("pr_seq2");
      stopin = 1'b1;
      tick();
      check_eq("pr_stop1", 32'(stateout), 32'd2);
      tick();
      stopin = 1'b0;
      check_eq("pr_stop2", 32'(stateout), 32'd0);
      check_eq("pr_icnt",  32'(countout), 32'd11);

      // load during RUN is ignored
      load_start(4'd0, 4'd15, 1'b1);
      loadin = 1'b1; loadvalin = 4'd12;
      tick();
      loadin = 1'b0;
      check_eq("rl_ign",   32'(countout), 32'd1);
      stopin = 1'b1;
      tick();
      tick();
      stopin = 1'b0;
      check_eq("rl_idle",  32'(stateout), 32'd0);
      check_eq("rl_cnt",   32'(countout), 32'd1);

      // start already at limit: DONE at E1 without a step
      load_start(4'd6, 4'd6, 1'b1);
      check_eq("al_tout",  32'(tout),     32'd0);
      tick();
      check_eq("al_done",  32'(stateout), 32'd3);
      check_eq("al_cnt",   32'(countout), 32'd6);
      tick();
      check_eq("al_idle",  32'(stateout), 32'd0);

      // up wrap 15 -> 0 -> 1 -> 2 then DONE
      load_start(4'd15, 4'd2, 1'b1);
      check_eq("uw_tout",  32'(tout),     32'hf);
      exp_q = {4'd0, 4'd1, 4'd2};
      drain_count("uw_seq");
      tick();
      check_eq("uw_done",  32'(doneout),  32'd1);
      check_eq("uw_dcnt",  32'(countout), 32'd2);
      tick();
`endif

      // reset mid-run at count 7
      load_start(4'd5, 4'd15, 1'b1);
      exp_q = {4'd6, 4'd7};
      drain_count("mr_seq");
      rstnin = 1'b0;
      #1;
      check_eq("mr_tout_in_rst", 32'(tout), 32'd0);
      tick();
      check_eq("mr_count", 32'(countout), 32'd0);
      check_eq("mr_state", 32'(stateout), 32'd0);
      check_eq("mr_busy",  32'(busyout),  32'd0);
      check_eq("mr_done",  32'(doneout),  32'd0);
      check_eq("mr_tout",  32'(tout),     32'd0);
      rstnin = 1'b1;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tff_count_sequencer.md
# tff_count_sequencer

Controller that sequences a bank of WIDTH T flip-flops as a programmable up/down counter. Each cycle it computes the per-bit toggle vector, applies it to the bank, and runs a start/pause/done state machine with load and terminal-count detection. It sits between lab-level control inputs (start, stop, load) and the T flip-flop register, and drives the toggle-enable vector the bank consumes.

## Interface
Parameters:
- WIDTH, 4: number of T flip-flops in the bank and width of all count buses; legal range is 2 to 16.

Ports:
- clkin  in  1  clock; all state updates on the rising edge.
- rstnin  in  1  reset; synchronous, active-low.
- startin  in  1  level, sampled each edge: begin or resume counting.
- stopin  in  1  level, sampled each edge: pause or abort counting.
- loadin  in  1  load loadvalin into the bank.
- dirin  in  1  count direction: 1 counts up, 0 counts down.
- loadvalin  in  WIDTH  preload value.
- limitin  in  WIDTH  terminal count.
- countout  out  WIDTH  current bank state, registered.
- tout  out  WIDTH  toggle vector applied at the coming edge; combinational from state, count and dirin.
- stateout  out  2  FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11.
- busyout  out  1  high in RUN or PAUSE.
- doneout  out  1  high exactly while in DONE.

## Operation
- Bank update:
  - countout <= countout ^ tout.
  - tout is all-zero outside RUN and in any RUN cycle where countout == limitin.
- Toggle generation in RUN:
  - Up: tout[0]=1; tout[i] = AND of countout[i-1:0].
  - Down: tout[0]=1; tout[i] = AND of ~countout[i-1:0].
  - Result is modulo 2^WIDTH. Up wraps 2^WIDTH-1 to 0; down wraps 0 to 2^WIDTH-1. No flag is raised on wrap.
- dirin is sampled every RUN cycle, so a direction change takes effect on the next edge.
- IDLE:
  - loadin: countout <= loadvalin.
  - startin with stopin low: go to RUN. If loadin is also high, the load occurs on the same edge.
  - Otherwise stay in IDLE; count holds.
- RUN:
  - stopin: go to PAUSE, count holds. stopin wins over startin.
  - Else, if countout == limitin: go to DONE, count holds.
  - Else: count steps by one.
  - loadin is ignored.
- PAUSE:
  - stopin: go to IDLE.
  - Else loadin: countout <= loadvalin, stay in PAUSE.
  - Else startin: go to RUN.
- DONE: lasts one cycle; count holds at limitin; then the next state is IDLE. Inputs are ignored in this state.
- Reset (rstnin low at an edge, in any state including mid-RUN):
  - state IDLE, countout 0, doneout 0, busyout 0, stateout 00.
  - tout reads 0 while in reset.

## Timing
- Start latency: startin sampled at edge E0 gives RUN after E0. The first count step lands at E1.
- Terminal latency: the count reaches limitin at edge En. DONE is entered at En+1, doneout is high for one cycle, and IDLE follows at En+2.
- Starting with countout == limitin: DONE at E1 with no count step.
- Steady state: one step per cycle in RUN.
- countout, stateout, busyout and doneout are registered. tout is combinational.

## Configuration
- TFF_SEQ_AUTORELOAD_EN defined:
  - DONE loads countout <= loadvalin and returns to RUN instead of IDLE.
  - doneout still pulses for one cycle per terminal count.
  - stopin sampled in DONE goes to PAUSE, with the reload still performed.
- TFF_SEQ_AUTORELOAD_EN undefined: DONE returns to IDLE as in Operation.

## Test plan
- Reset mid-run: WIDTH=4, load 5, start, then rstnin low for 1 edge at count 7 -> countout 0, stateout 00, busyout 0, doneout 0, tout 0000.
- Up count: load 3, limit 7, dirin 1, start at E0:
  - countout 4,5,6,7 at E1..E4.
  - doneout high E5..E6 only.
  - stateout 00 after E6.
  - tout at count 3 is 0111.
- Down wrap: load 1, limit 14, dirin 0, start -> countout 0, 15, 14; tout at count 0 is 1111; DONE follows the cycle after 14.
- Pause/resume and priority:
  - At count 5, stopin and startin high together -> PAUSE, count 5, tout 0000.
  - Then loadin with loadvalin 9 -> count 9.
  - Then startin -> counting resumes 10, 11.
  - Then stopin twice -> IDLE.
- Edge cases:
  - loadin during RUN leaves the count unchanged.
  - Start with load 6 and limit 6 -> DONE at E1 with no step.
  - WIDTH=4 up from 15 with limit 2 -> wraps 0, 1, 2, then DONE.
- Autoreload (macro defined): load 2, limit 4, up -> sequence 2,3,4,2,3,4 with one doneout pulse per pass; stopin during DONE -> PAUSE with count 2.
